pcs_link_ctrl: RTL and testbench
================================

PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles the sync block reset is held.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 1024: cycles in WAIT_SYNC before a retry.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive code_sync_status=1 cycles required for link up.
REQ-004 SHALL have parameter HOLDOFF_CYCLES, default 8: cycles in LINK_DOWN before a forced re-sync.
REQ-005 SHALL have port Clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port mr_main_reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port mr_restart, input, 1: management request to re-run the sync sequence.
REQ-008 SHALL have port clr_stats, input, 1: clears los_count and retry_count.
REQ-009 SHALL have port code_sync_status, input, 1: status from the synchronization FSM.
REQ-010 SHALL have port sync_rst, output, 1: drives the synchronization FSM reset input.
REQ-011 SHALL have port link_ok, output, 1: high only in LINK_UP.
REQ-012 SHALL have port link_state, output, 3: current state code.
REQ-013 SHALL have port timeout_pulse, output, 1: one-cycle pulse on each WAIT_SYNC timeout.
REQ-014 SHALL have port los_count, output, 8: count of LINK_UP->LINK_DOWN events, saturating at 255.
REQ-015 SHALL have port retry_count, output, 4: count of sync timeouts, saturating at 15.

Function
REQ-016 SHALL implement states RESET_HOLD=0, WAIT_SYNC=1, DEBOUNCE=2, LINK_UP=3, LINK_DOWN=4; codes 5-7 go to RESET_HOLD next cycle.
REQ-017 SHALL decode sync_rst, link_ok and link_state from the state register with zero added latency; sync_rst=1 only in RESET_HOLD.
REQ-018 SHALL use one shared cycle timer, cleared on every state change, incremented every cycle otherwise.
REQ-019 RESET_HOLD: SHALL stay exactly RST_CYCLES cycles, then go to WAIT_SYNC.
REQ-020 WAIT_SYNC: status=1 -> DEBOUNCE; otherwise, on the cycle timer equals SYNC_TIMEOUT-1 -> RESET_HOLD, timeout_pulse=1 that cycle, retry_count+1.
REQ-021 WAIT_SYNC: status=1 and timer expiry on the same cycle -> DEBOUNCE, no pulse, no increment.
REQ-022 DEBOUNCE: status=0 -> WAIT_SYNC; after DEBOUNCE_CYCLES cycles with status=1 each -> LINK_UP.
REQ-023 Timing: status first sampled 1 at edge k in WAIT_SYNC -> link_ok high from cycle k+1+DEBOUNCE_CYCLES if status stays 1.
REQ-024 LINK_UP: status=0 -> LINK_DOWN next cycle, los_count+1.
REQ-025 LINK_DOWN: status=1 -> DEBOUNCE; otherwise after HOLDOFF_CYCLES cycles -> RESET_HOLD.
REQ-026 mr_restart=1 in any state SHALL force RESET_HOLD next cycle, timer cleared, with priority over all transitions except reset.
REQ-027 mr_restart=1 while already in RESET_HOLD SHALL restart the RST_CYCLES count.
REQ-028 Counters SHALL saturate, never wrap; clr_stats=1 SHALL clear both counters and win over a same-cycle increment.
REQ-029 Timer width SHALL be clog2 of the largest timing parameter; all comparisons unsigned.

Reset
REQ-030 mr_main_reset=1 SHALL force state=RESET_HOLD, timer=0, los_count=0, retry_count=0, timeout_pulse=0; hence sync_rst=1, link_ok=0, link_state=0.
REQ-031 Reset SHALL have priority over mr_restart and clr_stats.
REQ-032 After reset deasserts, sync_rst SHALL stay high exactly RST_CYCLES further cycles.
REQ-033 Reset mid-LINK_UP SHALL drop link_ok on the next edge without incrementing los_count.

Structure
REQ-034 State codes and parameter defaults SHALL live in a shared include file used by pcs_link_ctrl and its bench.
REQ-035 The cycle timer SHALL be one sub-module, pcs_link_timer, with clear, increment enable and count output.
REQ-036 pcs_link_ctrl SHALL connect directly to the synchronization FSM: sync_rst to its reset input, its code_sync_status to the input here.

Verification
REQ-037 Reset 3 cycles then release, status=0 -> sync_rst high 4 more cycles; WAIT_SYNC (1) follows; timeout_pulse after 1024 cycles; retry_count=1.
REQ-038 Status=1 from cycle 10 of WAIT_SYNC -> link_state 2 at cycle 11, link_ok=1 at cycle 27.
REQ-039 Status drops 1 cycle at DEBOUNCE cycle 8 -> back to WAIT_SYNC; link_ok delayed a full 16 cycles from re-assertion.
REQ-040 LINK_UP, status=0 for 3 cycles then 1 -> los_count=1, state 4->2, no sync_rst; status=0 for 9 cycles -> RESET_HOLD.
REQ-041 Run 20 timeouts and 300 link drops -> retry_count=15, los_count=255; clr_stats on an increment cycle -> both 0.
REQ-042 mr_restart on a WAIT_SYNC timeout cycle -> RESET_HOLD, no retry increment ambiguity: timeout_pulse=0, retry_count unchanged.

Source files
------------

// File: rtl/pcs_link_ctrl_pkg.sv
// Shared definitions for the PCS link controller: state codes, parameter
// defaults, counter widths and timer sizing helpers.
package pcs_link_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_SYNC  = 3'd1,
    DEBOUNCE   = 3'd2,
    LINK_UP    = 3'd3,
    LINK_DOWN  = 3'd4
  } link_state_t;

  localparam int unsigned RST_CYCLES_DEF      = 4;
  localparam int unsigned SYNC_TIMEOUT_DEF    = 1024;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned HOLDOFF_CYCLES_DEF  = 8;

  localparam int unsigned LOS_W   = 8;
  localparam int unsigned RETRY_W = 4;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Timer only needs to reach (largest parameter - 1); keep at least one bit.
  function automatic int unsigned timer_width(input int unsigned largest);
    return (largest < 2) ? 1 : $clog2(largest);
  endfunction

endpackage

// File: rtl/pcs_link_timer.sv
// Shared cycle timer: synchronous clear, free-running increment otherwise.
module pcs_link_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: reset and clear take precedence over increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pcs_link_ctrl.sv
// PCS link controller: sequences the synchronization FSM reset, debounces
// code_sync_status into link_ok, and keeps saturating link statistics.
module pcs_link_ctrl
  import pcs_link_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = RST_CYCLES_DEF,
  parameter int unsigned SYNC_TIMEOUT    = SYNC_TIMEOUT_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
  input  logic               Clk,
  input  logic               mr_main_reset,
  input  logic               mr_restart,
  input  logic               clr_stats,
  input  logic               code_sync_status,
  output logic               sync_rst,
  output logic               link_ok,
  output logic [2:0]         link_state,
  output logic               timeout_pulse,
  output logic [LOS_W-1:0]   los_count,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned TW =
    timer_width(max4(RST_CYCLES, SYNC_TIMEOUT, DEBOUNCE_CYCLES, HOLDOFF_CYCLES));

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_TIMEOUT - 1);
  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);

  link_state_t        r_state;
  link_state_t        w_state_nxt;
  logic [TW-1:0]      w_timer;
  logic               w_timer_clr;
  logic               w_timeout;
  logic               w_los_event;
  logic [LOS_W-1:0]   r_los_count;
  logic [RETRY_W-1:0] r_retry_count;

  // A restart inside RESET_HOLD keeps the state but must still rewind the count.
  assign w_timer_clr = mr_restart || (w_state_nxt != r_state);

  pcs_link_timer #(
    .WIDTH (TW)
  ) u_timer (
    .i_clk   (Clk),
    .i_rst   (mr_main_reset),
    .i_clr   (w_timer_clr),
    .i_inc   (1'b1),
    .o_count (w_timer)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      r_state <= RESET_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus timeout / loss-of-sync event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_los_event = 1'b0;
    if (mr_restart) begin
      w_state_nxt = RESET_HOLD;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          if (w_timer == RST_LAST) w_state_nxt = WAIT_SYNC;
        end
        WAIT_SYNC: begin
          if (code_sync_status) begin
            w_state_nxt = DEBOUNCE;
          end else if (w_timer == SYNC_LAST) begin
            w_state_nxt = RESET_HOLD;
            w_timeout   = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!code_sync_status) begin
            w_state_nxt = WAIT_SYNC;
          end else if (w_timer == DEB_LAST) begin
            w_state_nxt = LINK_UP;
          end
        end
        LINK_UP: begin
          if (!code_sync_status) begin
            w_state_nxt = LINK_DOWN;
            w_los_event = 1'b1;
          end
        end
        LINK_DOWN: begin
          if (code_sync_status) begin
            w_state_nxt = DEBOUNCE;
          end else if (w_timer == HOLD_LAST) begin
            w_state_nxt = RESET_HOLD;
          end
        end
        default: w_state_nxt = RESET_HOLD;
      endcase
    end
  end

  // Saturating statistics; clear beats a same-cycle increment.
  always_ff @(posedge Clk) begin
    if (mr_main_reset || clr_stats) begin
      r_los_count   <= '0;
      r_retry_count <= '0;
    end else begin
      if (w_los_event && (r_los_count != '1)) r_los_count <= r_los_count + 1'b1;
      if (w_timeout && (r_retry_count != '1)) r_retry_count <= r_retry_count + 1'b1;
    end
  end

  assign sync_rst      = (r_state == RESET_HOLD);
  assign link_ok       = (r_state == LINK_UP);
  assign link_state    = r_state;
  assign timeout_pulse = w_timeout && !mr_main_reset;
  assign los_count     = r_los_count;
  assign retry_count   = r_retry_count;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed bench for pcs_link_ctrl using the default timing parameters.
module tb_pcs_link_ctrl;
  import pcs_link_ctrl_pkg::*;

  logic         Clk = 1'b0;
  logic         mr_main_reset = 1'b1;
  logic         mr_restart = 1'b0;
  logic         clr_stats = 1'b0;
  logic         code_sync_status = 1'b0;
  logic         sync_rst;
  logic         link_ok;
  logic [2:0]   link_state;
  logic         timeout_pulse;
  logic [7:0]   los_count;
  logic [3:0]   retry_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  pcs_link_ctrl #(
    .RST_CYCLES      (RST_CYCLES_DEF),
    .SYNC_TIMEOUT    (SYNC_TIMEOUT_DEF),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_DEF),
    .HOLDOFF_CYCLES  (HOLDOFF_CYCLES_DEF)
  ) dut (
    .Clk              (Clk),
    .mr_main_reset    (mr_main_reset),
    .mr_restart       (mr_restart),
    .clr_stats        (clr_stats),
    .code_sync_status (code_sync_status),
    .sync_rst         (sync_rst),
    .link_ok          (link_ok),
    .link_state       (link_state),
    .timeout_pulse    (timeout_pulse),
    .los_count        (los_count),
    .retry_count      (retry_count)
  );

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic go_wait_sync();
    code_sync_status = 1'b0;
    mr_restart = 1'b1;
    steps(1);
    mr_restart = 1'b0;
    steps(4);
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b1; mr_restart = 1'b1; clr_stats = 1'b1; code_sync_status = 1'b0;
    steps(3);
    n_cmp++; if (sync_rst !== 1'b1) begin n_fail++; $display("FAIL rst_sync_rst got %0d want 1", sync_rst); end
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL rst_link_ok got %0d want 0", link_ok); end
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", link_state); end
    n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %0d want 0", timeout_pulse); end
    n_cmp++; if (los_count !== 8'd0) begin n_fail++; $display("FAIL rst_los got %0d want 0", los_count); end
    n_cmp++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL rst_retry got %0d want 0", retry_count); end
    mr_main_reset = 1'b0; mr_restart = 1'b0; clr_stats = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sync_rst !== 1'b1) begin n_fail++; $display("FAIL hold_len cycle %0d got %0d want 1", i, sync_rst); end
      steps(1);
    end
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL rel_state got %0d want 1", link_state); end
    n_cmp++; if (sync_rst !== 1'b0) begin n_fail++; $display("FAIL rel_sync_rst got %0d want 0", sync_rst); end
  endtask

  task automatic test_timeout();
    steps(1022);
    n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_early_pulse got %0d want 0", timeout_pulse); end
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL to_wait_state got %0d want 1", link_state); end
    steps(1);
    n_cmp++; if (timeout_pulse !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %0d want 1", timeout_pulse); end
    steps(1);
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL to_state got %0d want 0", link_state); end
    n_cmp++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL to_retry got %0d want 1", retry_count); end
    n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end got %0d want 0", timeout_pulse); end
  endtask

  task automatic test_debounce_timing();
    go_wait_sync();
    steps(9);
    code_sync_status = 1'b1;
    steps(1);
    n_cmp++; if (link_state !== 3'd2) begin n_fail++; $display("FAIL db_state got %0d want 2", link_state); end
    steps(15);
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL db_early_ok got %0d want 0", link_ok); end
    steps(1);
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL db_link_ok got %0d want 1", link_ok); end
    n_cmp++; if (link_state !== 3'd3) begin n_fail++; $display("FAIL db_up_state got %0d want 3", link_state); end
  endtask

  task automatic test_debounce_glitch();
    go_wait_sync();
    code_sync_status = 1'b1;
    steps(8);
    n_cmp++; if (link_state !== 3'd2) begin n_fail++; $display("FAIL gl_in_db got %0d want 2", link_state); end
    code_sync_status = 1'b0;
    steps(1);
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL gl_back got %0d want 1", link_state); end
    code_sync_status = 1'b1;
    steps(16);
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL gl_early_ok got %0d want 0", link_ok); end
    steps(1);
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL gl_link_ok got %0d want 1", link_ok); end
  endtask

  task automatic test_link_drop();
    code_sync_status = 1'b0;
    steps(1);
    n_cmp++; if (link_state !== 3'd4) begin n_fail++; $display("FAIL ld_state got %0d want 4", link_state); end
    n_cmp++; if (los_count !== 8'd1) begin n_fail++; $display("FAIL ld_los got %0d want 1", los_count); end
    steps(2);
    n_cmp++; if (link_state !== 3'd4) begin n_fail++; $display("FAIL ld_hold got %0d want 4", link_state); end
    code_sync_status = 1'b1;
    steps(1);
    n_cmp++; if (link_state !== 3'd2) begin n_fail++; $display("FAIL ld_redb got %0d want 2", link_state); end
    n_cmp++; if (sync_rst !== 1'b0) begin n_fail++; $display("FAIL ld_sync_rst got %0d want 0", sync_rst); end
    steps(16);
    n_cmp++; if (link_state !== 3'd3) begin n_fail++; $display("FAIL ld_reup got %0d want 3", link_state); end
    code_sync_status = 1'b0;
    steps(8);
    n_cmp++; if (link_state !== 3'd4) begin n_fail++; $display("FAIL ld_holdoff got %0d want 4", link_state); end
    n_cmp++; if (los_count !== 8'd2) begin n_fail++; $display("FAIL ld_los2 got %0d want 2", los_count); end
    steps(1);
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL ld_resync got %0d want 0", link_state); end
    n_cmp++; if (sync_rst !== 1'b1) begin n_fail++; $display("FAIL ld_resync_rst got %0d want 1", sync_rst); end
  endtask

  task automatic test_timeout_tie();
    go_wait_sync();
    steps(1023);
    code_sync_status = 1'b1;
    #1;
    n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL tie_pulse got %0d want 0", timeout_pulse); end
    steps(1);
    n_cmp++; if (link_state !== 3'd2) begin n_fail++; $display("FAIL tie_state got %0d want 2", link_state); end
    n_cmp++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL tie_retry got %0d want 1", retry_count); end
  endtask

  task automatic test_restart();
    go_wait_sync();
    steps(1023);
    mr_restart = 1'b1;
    #1;
    n_cmp++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rs_pulse got %0d want 0", timeout_pulse); end
    steps(1);
    mr_restart = 1'b0;
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL rs_state got %0d want 0", link_state); end
    n_cmp++; if (retry_count !== 4'd1) begin n_fail++; $display("FAIL rs_retry got %0d want 1", retry_count); end
    steps(2);
    mr_restart = 1'b1;
    steps(1);
    mr_restart = 1'b0;
    steps(3);
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL rs_rehold got %0d want 0", link_state); end
    steps(1);
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL rs_release got %0d want 1", link_state); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) steps(1028);
    n_cmp++; if (retry_count !== 4'd15) begin n_fail++; $display("FAIL sat_retry got %0d want 15", retry_count); end
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL sat_wait got %0d want 1", link_state); end
    code_sync_status = 1'b1;
    steps(17);
    for (int i = 0; i < 300; i++) begin
      code_sync_status = 1'b0;
      steps(1);
      code_sync_status = 1'b1;
      steps(17);
    end
    n_cmp++; if (los_count !== 8'd255) begin n_fail++; $display("FAIL sat_los got %0d want 255", los_count); end
    n_cmp++; if (link_state !== 3'd3) begin n_fail++; $display("FAIL sat_up got %0d want 3", link_state); end
    code_sync_status = 1'b0; clr_stats = 1'b1;
    steps(1);
    clr_stats = 1'b0;
    n_cmp++; if (los_count !== 8'd0) begin n_fail++; $display("FAIL clr_los got %0d want 0", los_count); end
    n_cmp++; if (retry_count !== 4'd0) begin n_fail++; $display("FAIL clr_retry got %0d want 0", retry_count); end
    code_sync_status = 1'b1;
    steps(17);
    code_sync_status = 1'b0; clr_stats = 1'b1;
    steps(1);
    clr_stats = 1'b0;
    n_cmp++; if (los_count !== 8'd0) begin n_fail++; $display("FAIL clr_win got %0d want 0", los_count); end
    n_cmp++; if (link_state !== 3'd4) begin n_fail++; $display("FAIL clr_state got %0d want 4", link_state); end
  endtask

  task automatic test_reset_in_link_up();
    code_sync_status = 1'b1;
    steps(17);
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL ru_up got %0d want 1", link_ok); end
    code_sync_status = 1'b0; mr_main_reset = 1'b1;
    steps(1);
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL ru_ok got %0d want 0", link_ok); end
    n_cmp++; if (link_state !== 3'd0) begin n_fail++; $display("FAIL ru_state got %0d want 0", link_state); end
    n_cmp++; if (los_count !== 8'd0) begin n_fail++; $display("FAIL ru_los got %0d want 0", los_count); end
    mr_main_reset = 1'b0;
    steps(4);
    n_cmp++; if (link_state !== 3'd1) begin n_fail++; $display("FAIL ru_release got %0d want 1", link_state); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_debounce_timing();
    test_debounce_glitch();
    test_link_drop();
    test_timeout_tie();
    test_restart();
    test_saturation();
    test_reset_in_link_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
